// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// sequencing FSM states and nPC source selects.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   localparam logic NPC_SEQ    = 1'b0;
   localparam logic NPC_TARGET = 1'b1;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: ID-stage decode fields in,
// pipeline enables, bubble select, nPC source and forwarding selects out.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              freeze;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_dest;
   logic              id_rf_enable;
   logic              id_load_instr;
   logic              id_b_instr;
   logic              id_branch_taken;
   logic              id_ta_instr;

   logic              le_pc;
   logic              le_npc;
   logic              le_ifid;
   logic              nop_sel;
   logic              npc_src;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output freeze, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
             id_rf_enable, id_load_instr, id_b_instr, id_branch_taken, id_ta_instr,
      input  le_pc, le_npc, le_ifid, nop_sel, npc_src, fwd_a, fwd_b, stall_count
   );

   modport slave (
      input  freeze, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
             id_rf_enable, id_load_instr, id_b_instr, id_branch_taken, id_ta_instr,
      output le_pc, le_npc, le_ifid, nop_sel, npc_src, fwd_a, fwd_b, stall_count
   );

endinterface

// File: rtl/fwd_select.sv
// Operand forwarding select for one source register; nearest producer
// (EX, then MEM, then WB) wins, register 0 and unused operands read the RF.
module fwd_select
   import pipe_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic              use_src,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic              ex_rf,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_rf,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic              wb_rf,
   output logic [1:0]        sel
);

   // NOTE: assign a default before any branch so no path leaves sel
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      sel = FWD_RF;
      if (use_src && src != '0) begin
         if (ex_rf && ex_dest == src)
            sel = FWD_EX;
         else if (mem_rf && mem_dest == src)
            sel = FWD_MEM;
         else if (wb_rf && wb_dest == src)
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage PC/nPC pipeline: load-use stalls,
// bubble insertion, delayed-branch nPC select and operand forwarding.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic                  clk,
   input logic                  reset,
   pipeline_hazard_ctrl_if.slave bus
);

   logic [1:0]        state, state_nxt;
   logic [REG_AW-1:0] ex_dest, mem_dest, wb_dest;
   logic              ex_rf, mem_rf, wb_rf;
   logic              ex_load;
   logic [CNT_W-1:0]  stall_count;
   logic              hazard;
   logic              nop_sel;
   logic              le_all;
   logic              npc_src;
   logic [1:0]        fwd_a, fwd_b;

   // Only the EX-stage load flag matters: by MEM the loaded value is forwardable.
   assign hazard = ex_load && ex_rf && (ex_dest != '0) &&
                   ((bus.id_uses_rs && bus.id_rs == ex_dest) ||
                    (bus.id_uses_rt && bus.id_rt == ex_dest));

   always_comb begin
      le_all  = 1'b0;
      nop_sel = 1'b0;
      npc_src = NPC_SEQ;
      if (reset) begin
         nop_sel = 1'b1;
      end else if (bus.freeze) begin
         nop_sel = 1'b0;
      end else if (state == ST_INIT || hazard) begin
         nop_sel = 1'b1;
      end else begin
         le_all  = 1'b1;
         if ((bus.id_b_instr && bus.id_branch_taken) || bus.id_ta_instr)
            npc_src = NPC_TARGET;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:  state_nxt = ST_RUN;
         ST_RUN:   state_nxt = hazard ? ST_STALL : ST_RUN;
         ST_STALL: state_nxt = ST_RUN;
         default:  state_nxt = ST_INIT;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_INIT;
         ex_dest     <= '0;
         ex_rf       <= 1'b0;
         ex_load     <= 1'b0;
         mem_dest    <= '0;
         mem_rf      <= 1'b0;
         wb_dest     <= '0;
         wb_rf       <= 1'b0;
         stall_count <= '0;
      end else if (!bus.freeze) begin
         state <= state_nxt;
         if (nop_sel) begin
            ex_dest <= '0;
            ex_rf   <= 1'b0;
            ex_load <= 1'b0;
         end else begin
            ex_dest <= bus.id_dest;
            ex_rf   <= bus.id_rf_enable;
            ex_load <= bus.id_load_instr;
         end
         mem_dest <= ex_dest;
         mem_rf   <= ex_rf;
         wb_dest  <= mem_dest;
         wb_rf    <= mem_rf;
         if (state_nxt == ST_STALL && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end

   fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
      .src      (bus.id_rs),
      .use_src  (bus.id_uses_rs),
      .ex_dest  (ex_dest),
      .ex_rf    (ex_rf),
      .mem_dest (mem_dest),
      .mem_rf   (mem_rf),
      .wb_dest  (wb_dest),
      .wb_rf    (wb_rf),
      .sel      (fwd_a)
   );

   fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
      .src      (bus.id_rt),
      .use_src  (bus.id_uses_rt),
      .ex_dest  (ex_dest),
      .ex_rf    (ex_rf),
      .mem_dest (mem_dest),
      .mem_rf   (mem_rf),
      .wb_dest  (wb_dest),
      .wb_rf    (wb_rf),
      .sel      (fwd_b)
   );

   assign bus.le_pc       = le_all;
   assign bus.le_npc      = le_all;
   assign bus.le_ifid     = le_all;
   assign bus.nop_sel     = nop_sel;
   assign bus.npc_src     = npc_src;
   assign bus.fwd_a       = fwd_a;
   assign bus.fwd_b       = fwd_b;
   assign bus.stall_count = stall_count;

endmodule
